lfsr_bist: RTL and testbench

LFSR_BIST -- requirements
Module: lfsr_bist

---
 rtl/bist_pkg.sv | 17 +
 rtl/lfsr_step.sv | 23 ++
 rtl/lfsr_bist.sv | 135 +++++++++++++
 tb/tb_lfsr_bist.sv | 279 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/bist_pkg.sv
// Shared types for the LFSR BIST block: controller states and run modes.
// Latency: n/a (types only).
// Backpressure: n/a.
package bist_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_e;

  typedef enum logic {
    MODE_TPG  = 1'b0,
    MODE_MISR = 1'b1
  } mode_e;

endpackage

// File: rtl/lfsr_step.sv
// One Galois LFSR/MISR step: shift up, fold the top bit back through the taps, xor in data.
// Latency: purely combinational.
// Backpressure: none.
module lfsr_step #(
  parameter int WIDTH = 7
) (
  input  logic [WIDTH-1:0] cur,
  input  logic [WIDTH-1:0] poly,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] nxt
);

  localparam logic [WIDTH-1:0] X0_TERM = {{(WIDTH-1){1'b0}}, 1'b1};

  logic             fb;
  logic [WIDTH-1:0] taps;

  assign fb = cur[WIDTH-1];
  // The x^0 coefficient is always present, whatever poly[0] says.
  assign taps = (poly | X0_TERM) & {WIDTH{fb}};
  assign nxt  = {cur[WIDTH-2:0], 1'b0} ^ taps ^ din;

endmodule

// File: rtl/lfsr_bist.sv
// LFSR test-pattern generator / MISR signature compactor with IDLE-RUN-DONE control.
// Latency: first pattern the cycle after start; done pulses the cycle after the last step.
// Backpressure: none; MISR absorbs only on data_valid, start is ignored while busy.
module lfsr_bist
  import bist_pkg::*;
#(
  parameter int WIDTH = 7,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             mode,
  input  logic [WIDTH-1:0] seed,
  input  logic [WIDTH-1:0] poly,
  input  logic [CNT_W-1:0] num,
  input  logic             abort,
  input  logic [WIDTH-1:0] data_in,
  input  logic             data_valid,
  output logic [WIDTH-1:0] pattern,
  output logic             pattern_valid,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] signature
);

  localparam logic [CNT_W-1:0] CNT_ONE  = {{(CNT_W-1){1'b0}}, 1'b1};
  localparam logic [WIDTH-1:0] LFSR_ONE = {{(WIDTH-1){1'b0}}, 1'b1};

  state_e           state;
  mode_e            mode_q;
  logic [WIDTH-1:0] lfsr_q;
  logic [WIDTH-1:0] poly_q;
  logic [WIDTH-1:0] sig_q;
  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] num_q;
  logic             pv_q;
  logic             busy_q;
  logic             done_q;

  logic [WIDTH-1:0] step_din;
  logic [WIDTH-1:0] step_nxt;
  logic [WIDTH-1:0] seed_eff;
  logic [CNT_W-1:0] cnt_inc;
  logic             advance;
  logic             last;
  mode_e            mode_in;

  assign mode_in  = mode_e'(mode);
  // A TPG run seeded with zero would lock up, so it starts from 1 instead.
  assign seed_eff = (mode_in == MODE_TPG && seed == '0) ? LFSR_ONE : seed;
  assign step_din = (mode_q == MODE_MISR) ? data_in : '0;
  assign advance  = (state == ST_RUN) && ((mode_q == MODE_TPG) || data_valid);
  assign cnt_inc  = cnt_q + CNT_ONE;
  assign last     = advance && (cnt_inc == num_q);

  lfsr_step #(.WIDTH(WIDTH)) u_step (
    .cur  (lfsr_q),
    .poly (poly_q),
    .din  (step_din),
    .nxt  (step_nxt)
  );

  // Controller FSM with registered outputs; abort beats every other event.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= ST_IDLE;
      mode_q <= MODE_TPG;
      lfsr_q <= '0;
      poly_q <= '0;
      sig_q  <= '0;
      cnt_q  <= '0;
      num_q  <= '0;
      pv_q   <= 1'b0;
      busy_q <= 1'b0;
      done_q <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (start && !abort) begin
            lfsr_q <= seed_eff;
            poly_q <= poly;
            mode_q <= mode_in;
            num_q  <= num;
            cnt_q  <= '0;
            busy_q <= 1'b1;
            if (num == '0) begin
              state  <= ST_DONE;
              sig_q  <= seed_eff;
              done_q <= 1'b1;
              pv_q   <= 1'b0;
            end else begin
              state <= ST_RUN;
              pv_q  <= (mode_in == MODE_TPG);
            end
          end
        end
        ST_RUN: begin
          if (abort) begin
            state  <= ST_IDLE;
            busy_q <= 1'b0;
            pv_q   <= 1'b0;
          end else if (advance) begin
            lfsr_q <= step_nxt;
            cnt_q  <= cnt_inc;
            if (last) begin
              state  <= ST_DONE;
              sig_q  <= step_nxt;
              done_q <= 1'b1;
              pv_q   <= 1'b0;
            end
          end
        end
        ST_DONE: begin
          state  <= ST_IDLE;
          busy_q <= 1'b0;
          pv_q   <= 1'b0;
        end
        default: begin
          state  <= ST_IDLE;
          busy_q <= 1'b0;
          pv_q   <= 1'b0;
        end
      endcase
    end
  end

  assign pattern       = lfsr_q;
  assign pattern_valid = pv_q;
  assign busy          = busy_q;
  assign done          = done_q;
  assign signature     = sig_q;

endmodule

// File: tb/tb_lfsr_bist.sv
// Self-checking bench for lfsr_bist (WIDTH=7, CNT_W=16).
// Latency: n/a.
// Backpressure: n/a.
module tb_lfsr_bist;

  localparam int W = 7;
  localparam int C = 16;

  logic         clk;
  logic         rst_n;
  logic         start;
  logic         mode;
  logic [W-1:0] seed;
  logic [W-1:0] poly;
  logic [C-1:0] num;
  logic         abort;
  logic [W-1:0] data_in;
  logic         data_valid;
  logic [W-1:0] pattern;
  logic         pattern_valid;
  logic         busy;
  logic         done;
  logic [W-1:0] signature;

  int           checks;
  int           errors;
  logic [W-1:0] got[$];
  logic [W-1:0] last_sig;

  lfsr_bist #(.WIDTH(W), .CNT_W(C)) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .start         (start),
    .mode          (mode),
    .seed          (seed),
    .poly          (poly),
    .num           (num),
    .abort         (abort),
    .data_in       (data_in),
    .data_valid    (data_valid),
    .pattern       (pattern),
    .pattern_valid (pattern_valid),
    .busy          (busy),
    .done          (done),
    .signature     (signature)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  // Reference step as polynomial arithmetic: multiply by x, reduce modulo the
  // feedback polynomial when the x^W term appears, then add the data word.
  function automatic logic [W-1:0] ref_step(logic [W-1:0] s, logic [W-1:0] p, logic [W-1:0] d);
    int v;
    v = int'(s) * 2;
    if (v >= (1 << W)) v = (v - (1 << W)) ^ (int'(p) | 1);
    return v[W-1:0] ^ d;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // One complete run with scrambled side inputs; DUT checked every cycle.
  task automatic run(input bit md, input logic [W-1:0] sd, input logic [W-1:0] pl, input int n);
    logic [W-1:0] s;
    int           w;
    int           guard;
    bit           dv;
    logic [W-1:0] din;
    start = 1'b1; mode = md; seed = sd; poly = pl; num = C'(n);
    data_valid = 1'b1; data_in = W'($urandom);
    tick();
    start = 1'b0;
    s = (md == 1'b0 && sd == '0) ? W'(1) : sd;
    got.delete();
    w = 0;
    guard = 0;
    mode = 1'($urandom); seed = W'($urandom); poly = W'($urandom); num = C'($urandom);
    while (w < n) begin
      chk("run_busy", busy, 1);
      chk("run_done_low", done, 0);
      dv  = 1'($urandom);
      din = W'($urandom);
      data_valid = dv;
      data_in    = din;
      start      = ($urandom % 4 == 0);
      if (md == 1'b0) begin
        chk("tpg_valid", pattern_valid, 1);
        chk("tpg_pattern", pattern, s);
        got.push_back(pattern);
        s = ref_step(s, pl, '0);
        w++;
      end else begin
        chk("misr_valid_low", pattern_valid, 0);
        if (dv) begin
          s = ref_step(s, pl, din);
          w++;
        end
      end
      tick();
      guard++;
      if (guard > 8 * n + 50) begin
        checks++;
        errors++;
        $display("FAIL run_guard: got %0d words after %0d cycles, expected %0d", w, guard, n);
        break;
      end
    end
    start = 1'b0;
    data_valid = 1'b0;
    chk("end_done", done, 1);
    chk("end_busy", busy, 1);
    chk("end_valid_low", pattern_valid, 0);
    chk("end_signature", signature, s);
    last_sig = s;
    tick();
    chk("post_done_low", done, 0);
    chk("post_busy_low", busy, 0);
    chk("post_signature", signature, s);
  endtask

  typedef struct {
    bit           md;
    logic [W-1:0] sd;
    logic [W-1:0] pl;
    int           n;
    logic [W-1:0] sig;
  } vec_t;

  vec_t         tbl[6];
  logic [W-1:0] exp_pat8[8];
  bit           seen[128];
  int           distinct;
  bit           zero_seen;

  initial begin
    checks = 0; errors = 0; last_sig = '0;
    rst_n = 1'b0; start = 1'b0; mode = 1'b0; seed = '0; poly = '0; num = '0;
    abort = 1'b0; data_in = '0; data_valid = 1'b0;

    // Expected signatures worked by hand from the step rule.
    tbl[0] = '{1'b0, 7'h01, 7'h02, 8, 7'h06};
    tbl[1] = '{1'b0, 7'h00, 7'h02, 2, 7'h04};
    tbl[2] = '{1'b0, 7'h55, 7'h02, 0, 7'h55};
    tbl[3] = '{1'b0, 7'h01, 7'h02, 7, 7'h03};
    tbl[4] = '{1'b1, 7'h00, 7'h02, 0, 7'h00};
    tbl[5] = '{1'b0, 7'h40, 7'h02, 1, 7'h03};
    exp_pat8 = '{7'h01, 7'h02, 7'h04, 7'h08, 7'h10, 7'h20, 7'h40, 7'h03};

    #2;
    chk("reset_pattern", pattern, 0);
    chk("reset_valid", pattern_valid, 0);
    chk("reset_busy", busy, 0);
    chk("reset_done", done, 0);
    chk("reset_signature", signature, 0);
    tick();
    tick();
    rst_n = 1'b1;
    tick();

    for (int i = 0; i < 6; i++) begin
      run(tbl[i].md, tbl[i].sd, tbl[i].pl, tbl[i].n);
      chk($sformatf("tbl%0d_sig", i), signature, tbl[i].sig);
      if (i == 0)
        for (int k = 0; k < 8; k++) chk($sformatf("seq8_p%0d", k), got[k], exp_pat8[k]);
      if (i == 1) begin
        chk("zseed_p0", got[0], 7'h01);
        chk("zseed_p1", got[1], 7'h02);
      end
    end

    // Maximal-length sequence, then wrap-around on the 128th pattern.
    run(1'b0, 7'h01, 7'h02, 127);
    for (int k = 0; k < 128; k++) seen[k] = 1'b0;
    distinct = 0; zero_seen = 1'b0;
    foreach (got[k]) begin
      if (got[k] == '0) zero_seen = 1'b1;
      if (!seen[got[k]]) distinct++;
      seen[got[k]] = 1'b1;
    end
    chk("mls_distinct", distinct, 127);
    chk("mls_no_zero", zero_seen, 0);
    run(1'b0, 7'h01, 7'h02, 128);
    chk("mls_repeat", got[127], 7'h01);
    chk("mls128_sig", signature, 7'h02);

    // MISR with a data_valid gap; data_valid outside RUN must be ignored.
    data_valid = 1'b1; data_in = 7'h7f;
    start = 1'b1; mode = 1'b1; seed = 7'h00; poly = 7'h02; num = 16'd2;
    tick();
    start = 1'b0; data_in = 7'h01;
    chk("misr_pat_seed", pattern, 7'h00);
    tick();
    data_valid = 1'b0; data_in = 7'h7f;
    chk("misr_gap_done", done, 0);
    chk("misr_word1", pattern, 7'h01);
    tick();
    data_valid = 1'b1; data_in = 7'h00;
    chk("misr_gap_hold", pattern, 7'h01);
    chk("misr_mid_done", done, 0);
    tick();
    data_valid = 1'b0;
    chk("misr_done", done, 1);
    chk("misr_sig", signature, 7'h02);
    chk("misr_valid_low", pattern_valid, 0);
    last_sig = 7'h02;
    tick();
    chk("misr_done_once", done, 0);

    // Start during RUN is ignored; abort at pattern 3 freezes everything.
    start = 1'b1; mode = 1'b0; seed = 7'h01; poly = 7'h02; num = 16'd8;
    tick();
    start = 1'b0;
    chk("ab_p1", pattern, 7'h01);
    tick();
    chk("ab_p2", pattern, 7'h02);
    start = 1'b1; seed = 7'h33; num = 16'd1;
    tick();
    start = 1'b0;
    chk("ab_p3", pattern, 7'h04);
    chk("ab_p3_valid", pattern_valid, 1);
    abort = 1'b1;
    tick();
    abort = 1'b0;
    chk("ab_busy", busy, 0);
    chk("ab_valid", pattern_valid, 0);
    chk("ab_frozen", pattern, 7'h04);
    chk("ab_sig", signature, last_sig);
    for (int k = 0; k < 3; k++) begin
      chk("ab_no_done", done, 0);
      tick();
    end

    // Reset mid-run at pattern 5, then first start behaves normally.
    start = 1'b1; mode = 1'b0; seed = 7'h01; poly = 7'h02; num = 16'd8;
    tick();
    start = 1'b0;
    for (int k = 0; k < 4; k++) tick();
    chk("rst_p5", pattern, 7'h10);
    #2;
    rst_n = 1'b0;
    #1;
    chk("rst_busy", busy, 0);
    chk("rst_valid", pattern_valid, 0);
    chk("rst_done", done, 0);
    chk("rst_pattern", pattern, 0);
    chk("rst_signature", signature, 0);
    tick();
    rst_n = 1'b1;
    tick();
    chk("rst_stay_idle", busy, 0);
    run(1'b0, 7'h01, 7'h02, 3);
    chk("rst_first_sig", signature, 7'h08);

    // Randomized runs against the reference model.
    for (int r = 0; r < 25; r++)
      run(1'($urandom), W'($urandom), W'($urandom), $urandom_range(0, 20));

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
